keypad_scanner: RTL and testbench

- Front end for the calculator's general controller (gencon); drives the controller's user-input side.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the rows, and decodes one key per press.
- Outputs:
  - digits as a 4-bit value with a one-cycle read strobe;
  - operators as a held one-hot code;
  - "=" as a one-cycle pulse;
  - "*" as a clear pulse.

---
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner, debouncer and key decoder
//
// Ports:
//   clk            system clock
//   RST            synchronous active-high reset
//   row_in[3:0]    keypad rows, active-low, asynchronous (bit 0 = top row)
//   col_out[3:0]   column drive, one-hot active-low (bit 0 = leftmost column)
//   keypad_input   last accepted digit, held until the next digit
//   read_input     one-cycle strobe, the cycle after keypad_input updates
//   operator_input held one-hot operator: 001 add, 010 sub, 100 mul
//   equal_input    one-cycle "=" pulse
//   clear_out      one-cycle clear pulse
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_out
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        DECODE,
        STROBE,
        WAIT_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    rows_m, rows_s;
    logic [3:0]    cand, cand_nx;
    logic [1:0]    col_idx, col_idx_nx;
    logic [SW-1:0] scan_cnt, scan_cnt_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [3:0]    keypad_nx;
    logic [2:0]    op_nx;

    logic [1:0]    row_idx;
    logic          one_low;
    logic          key_is_digit, key_is_eq, key_is_clr;
    logic [3:0]    key_digit;
    logic [2:0]    key_op;

    assign col_out = ~(4'b0001 << col_idx);

    // Row index of the single low row in the candidate; one_low is false
    // for ghost/multi-key patterns, which are then swallowed without output.
    always_comb begin
        row_idx = 2'd0;
        one_low = 1'b1;
        case (cand)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        key_is_digit = 1'b0;
        key_is_eq    = 1'b0;
        key_is_clr   = 1'b0;
        key_digit    = 4'd0;
        key_op       = 3'b000;
        case ({row_idx, col_idx})
            4'd0:  begin key_is_digit = 1'b1; key_digit = 4'd1; end
            4'd1:  begin key_is_digit = 1'b1; key_digit = 4'd2; end
            4'd2:  begin key_is_digit = 1'b1; key_digit = 4'd3; end
            4'd3:  key_op = 3'b001;
            4'd4:  begin key_is_digit = 1'b1; key_digit = 4'd4; end
            4'd5:  begin key_is_digit = 1'b1; key_digit = 4'd5; end
            4'd6:  begin key_is_digit = 1'b1; key_digit = 4'd6; end
            4'd7:  key_op = 3'b010;
            4'd8:  begin key_is_digit = 1'b1; key_digit = 4'd7; end
            4'd9:  begin key_is_digit = 1'b1; key_digit = 4'd8; end
            4'd10: begin key_is_digit = 1'b1; key_digit = 4'd9; end
            4'd11: key_op = 3'b100;
            4'd12: key_is_clr = 1'b1;
            4'd13: begin key_is_digit = 1'b1; key_digit = 4'd0; end
            4'd14: key_is_eq = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cand_nx      = cand;
        col_idx_nx   = col_idx;
        scan_cnt_nx  = scan_cnt;
        cnt_nx       = cnt;
        keypad_nx    = keypad_input;
        op_nx        = operator_input;
        read_input   = 1'b0;
        equal_input  = 1'b0;
        clear_out    = 1'b0;
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_nx = '0;
                    if (rows_s != 4'b1111) begin
                        cand_nx  = rows_s;
                        cnt_nx   = '0;
                        state_nx = DEBOUNCE;
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                    end
                end else begin
                    scan_cnt_nx = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rows_s != cand) begin
                    state_nx    = SCAN;
                    col_idx_nx  = col_idx + 2'd1;
                    scan_cnt_nx = '0;
                    cnt_nx      = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx   = '0;
                    state_nx = one_low ? DECODE : WAIT_RELEASE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DECODE: begin
                cnt_nx   = '0;
                state_nx = WAIT_RELEASE;
                if (key_is_digit) begin
                    keypad_nx = key_digit;
                    state_nx  = STROBE;
                end
                if (key_op != 3'b000) begin
                    op_nx = key_op;
                end
                // "=" and "*" both end the held operator; it stays visible
                // during the pulse cycle and drops on the following edge.
                if (key_is_eq) begin
                    equal_input = 1'b1;
                    op_nx       = 3'b000;
                end
                if (key_is_clr) begin
                    clear_out = 1'b1;
                    op_nx     = 3'b000;
                end
            end
            STROBE: begin
                read_input = 1'b1;
                cnt_nx     = '0;
                state_nx   = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (rows_s == 4'b1111) begin
                    if (cnt == DEB_LAST) begin
                        cnt_nx      = '0;
                        state_nx    = SCAN;
                        col_idx_nx  = col_idx + 2'd1;
                        scan_cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rows_m         <= 4'b1111;
            rows_s         <= 4'b1111;
            state          <= SCAN;
            cand           <= 4'b1111;
            col_idx        <= 2'd0;
            scan_cnt       <= '0;
            cnt            <= '0;
            keypad_input   <= 4'd0;
            operator_input <= 3'b000;
        end else begin
            rows_m         <= row_in;
            rows_s         <= rows_m;
            state          <= state_nx;
            cand           <= cand_nx;
            col_idx        <= col_idx_nx;
            scan_cnt       <= scan_cnt_nx;
            cnt            <= cnt_nx;
            keypad_input   <= keypad_nx;
            operator_input <= op_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a matrix model
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int K_READ = 0;
    localparam int K_OP   = 1;
    localparam int K_EQ   = 2;
    localparam int K_CLR  = 3;

    typedef struct {
        int         kind;
        logic [3:0] val;
        bit         adj;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] keypad_input;
    logic       read_input;
    logic [2:0] operator_input;
    logic       equal_input;
    logic       clear_out;

    logic [15:0] pressed = 16'h0;
    exp_t        sb[$];
    logic [2:0]  held_op = 3'b000;
    logic [2:0]  prev_op = 3'b000;
    string       labels = "123A456B789C*0#D";
    int          ntests = 0;
    int          nfail = 0;
    int          cycle = 0;
    int          last_pulse = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk),
        .RST(RST),
        .row_in(row_in),
        .col_out(col_out),
        .keypad_input(keypad_input),
        .read_input(read_input),
        .operator_input(operator_input),
        .equal_input(equal_input),
        .clear_out(clear_out)
    );

    // Matrix: a row reads low when any pressed key on it sits in a driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what one clean, isolated press of key idx must produce.
    function automatic void model_press(input int idx);
        byte  ch;
        exp_t e;
        ch = labels[idx];
        e.adj = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            e.kind = K_READ; e.val = 4'(ch - 8'h30); sb.push_back(e);
        end else if (ch == "A" || ch == "B" || ch == "C") begin
            e.kind = K_OP;
            e.val  = (ch == "A") ? 4'd1 : (ch == "B") ? 4'd2 : 4'd4;
            if (e.val[2:0] != held_op) sb.push_back(e);
            held_op = e.val[2:0];
        end else if (ch == "#" || ch == "*") begin
            e.kind = (ch == "#") ? K_EQ : K_CLR;
            e.val  = {1'b0, held_op};
            sb.push_back(e);
            if (held_op != 3'b000) begin
                e.kind = K_OP; e.val = 4'd0; e.adj = 1'b1; sb.push_back(e);
            end
            held_op = 3'b000;
        end
    endfunction

    task automatic get_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.val = 4'd0; e.adj = 1'b0;
        if (sb.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_output: got kind %0d expected none (cycle %0d)", kind, cycle);
        end else begin
            e = sb.pop_front();
            chk("output_kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        int   np;
        if (RST !== 1'b1) begin
            np = int'(read_input) + int'(equal_input) + int'(clear_out);
            if (np > 0) chk("pulse_exclusive", np, 1);
            if (read_input) begin
                get_exp(K_READ, e, ok);
                if (ok) chk("digit_value", int'(keypad_input), int'(e.val));
                last_pulse = cycle;
            end
            if (equal_input) begin
                get_exp(K_EQ, e, ok);
                if (ok) chk("op_held_at_equal", int'(operator_input), int'(e.val));
                last_pulse = cycle;
            end
            if (clear_out) begin
                get_exp(K_CLR, e, ok);
                last_pulse = cycle;
            end
            if (operator_input != prev_op) begin
                get_exp(K_OP, e, ok);
                if (ok) begin
                    chk("op_value", int'(operator_input), int'(e.val));
                    if (e.adj) chk("op_drop_timing", cycle - last_pulse, 1);
                end
            end
        end
        prev_op = operator_input;
    end

    task automatic press(input int idx, input int hold, input int gap);
        model_press(idx);
        pressed[idx] = 1'b1;
        repeat (hold) tick();
        pressed = 16'h0;
        repeat (gap) tick();
    endtask

    task automatic press2(input int a, input int b, input int hold, input int gap);
        pressed[a] = 1'b1;
        pressed[b] = 1'b1;
        repeat (hold) tick();
        pressed = 16'h0;
        repeat (gap) tick();
    endtask

    task automatic check_resume(input logic [3:0] frozen, input string name);
        int moved = 0;
        for (int i = 0; i < 24 && moved == 0; i++) begin
            tick();
            if (col_out != frozen) moved = 1;
        end
        chk(name, moved, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_col_out"}, int'(col_out), 4'b1110);
        chk({tag, "_keypad_input"}, int'(keypad_input), 0);
        chk({tag, "_read_input"}, int'(read_input), 0);
        chk({tag, "_operator_input"}, int'(operator_input), 0);
        chk({tag, "_equal_input"}, int'(equal_input), 0);
        chk({tag, "_clear_out"}, int'(clear_out), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        int         run;
        int         c, r1, r2;

        RST = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        RST = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_col = 4'b1111 ^ (4'b0001 << ((k / SD) % 4));
            chk("col_step", int'(col_out), int'(exp_col));
        end

        // "1" held long: one strobe, then scanning resumes past column 0.
        model_press(0);
        pressed[0] = 1'b1;
        repeat (40) tick();
        pressed = 16'h0;
        check_resume(4'b1110, "resume_after_1");
        repeat (10) tick();

        // 1, 1, B, 1, 0, #
        press(0, 40, 20);
        press(0, 40, 20);
        press(7, 40, 20);
        press(0, 40, 20);
        press(13, 40, 20);
        press(14, 40, 20);

        // Bouncing "5" never settles for long enough to be accepted.
        for (int i = 0; i < 10; i++) begin
            pressed[5] = ~pressed[5];
            repeat (3) tick();
        end
        pressed = 16'h0;
        repeat (20) tick();
        press(5, 40, 20);

        // "2" and "5" together: two rows low in one column.
        pressed[1] = 1'b1;
        pressed[5] = 1'b1;
        repeat (40) tick();
        pressed = 16'h0;
        check_resume(4'b1101, "resume_after_double");
        repeat (10) tick();

        press(11, 40, 20);
        press(12, 40, 20);

        // Reset while "7" is being debounced (column 0 frozen past its window).
        pressed[8] = 1'b1;
        run = 0;
        for (int i = 0; i < 100 && run < SD + 2; i++) begin
            tick();
            if (col_out == 4'b1110) run++;
            else run = 0;
        end
        chk("debounce_reached", int'(run >= SD + 2), 1);
        RST = 1'b1;
        pressed = 16'h0;
        tick();
        check_reset_outputs("midreset");
        RST = 1'b0;
        held_op = 3'b000;
        repeat (40) tick();

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                c  = $urandom_range(0, 3);
                r1 = $urandom_range(0, 3);
                r2 = (r1 + $urandom_range(1, 3)) % 4;
                press2(r1 * 4 + c, r2 * 4 + c, $urandom_range(40, 60), $urandom_range(20, 30));
            end else begin
                press($urandom_range(0, 15), $urandom_range(40, 60), $urandom_range(20, 30));
            end
        end

        repeat (60) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
